// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the screen-memory arbiter.
package vram_pkg;

  localparam int VRAM_AW = 14;
  localparam int VID_AW = 13;
  localparam int FETCH_PHASE_BIT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } stateT;

endpackage

// File: rtl/vram_arbiter.sv
// ULA-style arbiter for the single VRAM port: video fetch wins, CPU uses free ce slots.
// Optional SHADOW_SCREEN_EN: video bank taken from screen_sel, latched at hphase 0.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic [3:0]          hphase,
  input  logic                fetch_window,
  input  logic [VID_AW-1:0]   vid_addr,
  input  logic                screen_sel,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [VRAM_AW-1:0]  cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic [7:0]          cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_wait,
  output logic [VRAM_AW-1:0]  mem_addr,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  output logic [1:0]          dbgState
);

  // Handshake: cpu_req is held until cpu_ack; cpu_ack lasts one ce period and
  // cpu_wait is simply cpu_req && !cpu_ack.
  stateT state, stateNext;
  logic  videoSlot;
  logic  grant;
  logic  complete;
  logic  isWrite;
  logic  vbank;

  assign videoSlot = fetch_window && hphase[FETCH_PHASE_BIT];
  assign cpu_wait  = cpu_req && !cpu_ack;
  assign dbgState  = state;

`ifdef SHADOW_SCREEN_EN
  logic bankReg;

  // Sampled only at the start of a cell so a fetch group never mixes banks.
  always_ff @(posedge clock) begin
    if (reset) begin
      bankReg <= 1'b0;
    end else if (ce && hphase == 4'd0) begin
      bankReg <= screen_sel;
    end
  end

  assign vbank = bankReg;
`else
  logic [3:0] unusedBits;
  assign unusedBits = {screen_sel, hphase[2:0]};
  assign vbank = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    complete  = 1'b0;
    if (ce) begin
      case (state)
        IDLE: begin
          if (cpu_req && !videoSlot) begin
            grant     = 1'b1;
            stateNext = ACCESS;
          end
        end
        ACCESS: begin
          complete  = 1'b1;
          stateNext = ACK;
        end
        ACK:     stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // grant and videoSlot are mutually exclusive, so the address mux has no priority clash.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      isWrite   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (grant) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we;
        isWrite   <= cpu_we;
      end else if (ce && videoSlot) begin
        mem_addr <= {vbank, vid_addr};
      end
      if (complete) begin
        cpu_ack <= 1'b1;
        if (!isWrite) begin
          cpu_rdata <= mem_rdata;
        end
      end else if (ce && state == ACK) begin
        cpu_ack <= 1'b0;
      end
    end
  end

endmodule
